// File: rtl/call_meter_mc.sv
// Multi-channel prepaid call billing meter: per-line IDLE/ACTIVE/CUT FSM with
// minute timer, balance deduction, low-balance warning and forced cut-off.
// Optional CALL_METER_DISCOUNT_EN adds a per-line half-rate `discount` input.
module call_meter_mc #(
    parameter int CH            = 4,
    parameter int TIME_W        = 9,
    parameter int MONEY_W       = 11,
    parameter int TICKS_PER_MIN = 600,
    parameter int RATE_T1       = 1,
    parameter int RATE_T2       = 3,
    parameter int RATE_T3       = 6,
    parameter int WARN_LEVEL    = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CH-1:0]           calling,
    input  logic [2*CH-1:0]         call_type,
`ifdef CALL_METER_DISCOUNT_EN
    input  logic [CH-1:0]           discount,
`endif
    input  logic                    load_en,
    input  logic [$clog2(CH)-1:0]   load_ch,
    input  logic [MONEY_W-1:0]      load_val,
    output logic [CH*TIME_W-1:0]    outtime,
    output logic [CH*MONEY_W-1:0]   outmoney,
    output logic [CH-1:0]           write,
    output logic [CH-1:0]           warn,
    output logic [CH-1:0]           cut
);

    localparam int TICK_W = (TICKS_PER_MIN > 2) ? $clog2(TICKS_PER_MIN) : 1;
    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICKS_PER_MIN - 1);
    localparam logic [MONEY_W-1:0] R1   = MONEY_W'(RATE_T1);
    localparam logic [MONEY_W-1:0] R2   = MONEY_W'(RATE_T2);
    localparam logic [MONEY_W-1:0] R3   = MONEY_W'(RATE_T3);
    localparam logic [MONEY_W-1:0] WARN = MONEY_W'(WARN_LEVEL);

    typedef enum logic [1:0] {IDLE, ACTIVE, CUT} state_t;

    for (genvar i = 0; i < CH; i++) begin : g_line
        state_t               state, state_nx;
        logic [MONEY_W-1:0]   rate, rate_nx, money, money_nx, type_rate;
        logic [TIME_W-1:0]    mins, mins_nx;
        logic [TICK_W-1:0]    tick, tick_nx;
        logic                 write_q, write_nx, warn_q, warn_nx, cut_q;
        logic                 load_hit;

        // load_ch values at or above CH can never equal a line index, so they drop out here
        assign load_hit = load_en && (32'(load_ch) == i);

        always_comb begin
            type_rate = '0;
            case (call_type[2*i +: 2])
                2'b01:   type_rate = R1;
                2'b10:   type_rate = R2;
                2'b11:   type_rate = R3;
                default: type_rate = '0;
            endcase
`ifdef CALL_METER_DISCOUNT_EN
            if (discount[i])
                type_rate = type_rate >> 1;
`endif
        end

        always_comb begin
            state_nx = state;
            rate_nx  = rate;
            money_nx = money;
            mins_nx  = mins;
            tick_nx  = tick;
            write_nx = 1'b0;
            case (state)
                IDLE: begin
                    // a load takes priority; the still-high calling level starts the call next cycle
                    if (load_hit) begin
                        money_nx = load_val;
                    end else if (calling[i]) begin
                        rate_nx = type_rate;
                        mins_nx = '0;
                        tick_nx = '0;
                        if (money >= type_rate) begin
                            money_nx = money - type_rate;
                            state_nx = ACTIVE;
                        end else begin
                            state_nx = CUT;
                        end
                    end
                end
                ACTIVE: begin
                    if (!calling[i]) begin
                        write_nx = 1'b1;
                        state_nx = IDLE;
                    end else if (tick == TICK_LAST) begin
                        tick_nx = '0;
                        if (mins != '1)
                            mins_nx = mins + 1'b1;
                        if (money >= rate)
                            money_nx = money - rate;
                        else
                            state_nx = CUT;
                    end else begin
                        tick_nx = tick + 1'b1;
                    end
                end
                CUT: begin
                    if (!calling[i]) begin
                        write_nx = 1'b1;
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
            warn_nx = (state_nx == ACTIVE) && (money_nx < WARN);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                state <= IDLE;
            else
                state <= state_nx;
        end

        // cut is registered from the next state so it shares the state's timing
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rate    <= '0;
                money   <= '0;
                mins    <= '0;
                tick    <= '0;
                write_q <= 1'b0;
                warn_q  <= 1'b0;
                cut_q   <= 1'b0;
            end else begin
                rate    <= rate_nx;
                money   <= money_nx;
                mins    <= mins_nx;
                tick    <= tick_nx;
                write_q <= write_nx;
                warn_q  <= warn_nx;
                cut_q   <= (state_nx == CUT);
            end
        end

        assign outtime[i*TIME_W +: TIME_W]    = mins;
        assign outmoney[i*MONEY_W +: MONEY_W] = money;
        assign write[i] = write_q;
        assign warn[i]  = warn_q;
        assign cut[i]   = cut_q;
    end

endmodule

// File: tb/tb_call_meter_mc.sv
// Scoreboard bench for call_meter_mc: each call's outcome is predicted from
// duration/balance arithmetic and checked when the line's write pulse appears.
module tb_call_meter_mc;

    localparam int CH      = 4;
    localparam int TIME_W  = 4;
    localparam int MONEY_W = 11;
    localparam int TPM     = 10;
    localparam int WARN    = 10;
    localparam int RATES [4] = '{0, 1, 3, 6};
    localparam int TMAX    = (1 << TIME_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [CH-1:0]         calling = '0;
    logic [2*CH-1:0]       call_type = '0;
    logic                  load_en = 1'b0;
    logic [$clog2(CH)-1:0] load_ch = '0;
    logic [MONEY_W-1:0]    load_val = '0;
    logic [CH*TIME_W-1:0]  outtime;
    logic [CH*MONEY_W-1:0] outmoney;
    logic [CH-1:0]         write, warn, cut;
`ifdef CALL_METER_DISCOUNT_EN
    logic [CH-1:0]         discount = '0;
`endif

    call_meter_mc #(
        .CH(CH), .TIME_W(TIME_W), .MONEY_W(MONEY_W), .TICKS_PER_MIN(TPM),
        .RATE_T1(1), .RATE_T2(3), .RATE_T3(6), .WARN_LEVEL(WARN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .calling(calling), .call_type(call_type),
`ifdef CALL_METER_DISCOUNT_EN
        .discount(discount),
`endif
        .load_en(load_en), .load_ch(load_ch), .load_val(load_val),
        .outtime(outtime), .outmoney(outmoney), .write(write), .warn(warn), .cut(cut)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        int m;
        bit c;
        bit w;
    } exp_t;

    exp_t expq [CH][$];
    int   bal [CH];
    int   errors = 0;
    int   checks = 0;

    function automatic void check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    // Whole-call outcome: the call holds calling for n sampled edges; minute
    // boundaries fall every TPM edges after the start; charging stops once the
    // balance cannot cover another minute.
    function automatic exp_t predict(input int b, input int r, input int n);
        exp_t e;
        int wraps, aff, charged;
        wraps = (n - 1) / TPM;
        if (b < r) begin
            e.t = 0; e.m = b; e.c = 1'b1; e.w = 1'b0;
        end else begin
            aff     = (r == 0) ? wraps : (b - r) / r;
            charged = (wraps < aff) ? wraps : aff;
            e.c     = (wraps > aff);
            e.t     = e.c ? aff + 1 : wraps;
            if (e.t > TMAX) e.t = TMAX;
            e.m     = b - r * (1 + charged);
            e.w     = !e.c && (e.m < WARN);
        end
        return e;
    endfunction

    function automatic int effRate(input int ty, input bit disc);
        int r;
        r = RATES[ty];
`ifdef CALL_METER_DISCOUNT_EN
        if (disc) r = r >> 1;
`else
        if (disc) r = RATES[ty];
`endif
        return r;
    endfunction

    // monitor: pops one expectation per write pulse; cut/warn are taken from
    // the cycle just before release
    initial begin
        logic [CH-1:0] prevCut;
        logic [CH-1:0] prevWarn;
        exp_t e;
        prevCut = '0;
        prevWarn = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < CH; i++) begin
                if (write[i]) begin
                    if (expq[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_write line %0d: got pulse, expected none", i);
                    end else begin
                        e = expq[i].pop_front();
                        check($sformatf("outtime[%0d]", i), longint'(outtime[i*TIME_W +: TIME_W]), e.t);
                        check($sformatf("outmoney[%0d]", i), longint'(outmoney[i*MONEY_W +: MONEY_W]), e.m);
                        check($sformatf("cut_before_release[%0d]", i), longint'(prevCut[i]), longint'(e.c));
                        check($sformatf("warn_before_release[%0d]", i), longint'(prevWarn[i]), longint'(e.w));
                        check($sformatf("cut_after_release[%0d]", i), longint'(cut[i]), 0);
                    end
                end
            end
            prevCut = cut;
            prevWarn = warn;
        end
    end

    task automatic loadLine(input int ln, input int v, input bit accepted);
        @(negedge clk);
        load_en = 1'b1;
        load_ch = $clog2(CH)'(ln);
        load_val = MONEY_W'(v);
        @(negedge clk);
        load_en = 1'b0;
        if (accepted) bal[ln] = v;
    endtask

    task automatic applyStimulus(input int ln, input int ty, input int n, input bit disc);
        exp_t e;
        e = predict(bal[ln], effRate(ty, disc), n);
        bal[ln] = e.m;
        expq[ln].push_back(e);
        @(negedge clk);
        call_type[2*ln +: 2] = 2'(ty);
`ifdef CALL_METER_DISCOUNT_EN
        discount[ln] = disc;
`endif
        calling[ln] = 1'b1;
        repeat (n) @(negedge clk);
        calling[ln] = 1'b0;
    endtask

    // load and call start on the same edge: the call begins one edge later
    task automatic loadAndCall(input int ln, input int ty, input int n, input int v);
        exp_t e;
        e = predict(v, effRate(ty, 1'b0), n - 1);
        bal[ln] = e.m;
        expq[ln].push_back(e);
        @(negedge clk);
        call_type[2*ln +: 2] = 2'(ty);
`ifdef CALL_METER_DISCOUNT_EN
        discount[ln] = 1'b0;
`endif
        load_en = 1'b1;
        load_ch = $clog2(CH)'(ln);
        load_val = MONEY_W'(v);
        calling[ln] = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        repeat (n - 1) @(negedge clk);
        calling[ln] = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        check({tag, "_outtime"}, longint'(outtime), 0);
        check({tag, "_outmoney"}, longint'(outmoney), 0);
        check({tag, "_write"}, longint'(write), 0);
        check({tag, "_warn"}, longint'(warn), 0);
        check({tag, "_cut"}, longint'(cut), 0);
    endtask

    initial begin
        for (int i = 0; i < CH; i++) bal[i] = 0;
        repeat (3) @(negedge clk);
        checkOutput("reset");
        rst_n = 1'b1;

        // directed scenarios
        loadLine(0, 100, 1'b1);
        applyStimulus(0, 1, 650, 1'b0);
        loadLine(1, 20, 1'b1);
        applyStimulus(1, 3, 100, 1'b0);
        loadLine(2, 2, 1'b1);
        applyStimulus(2, 2, 6, 1'b0);
        applyStimulus(3, 0, 40, 1'b0);
        loadLine(0, 50, 1'b1);
        fork
            applyStimulus(0, 2, 45, 1'b0);
            begin
                repeat (5) @(negedge clk);
                loadLine(0, 999, 1'b0);
            end
        join
        loadAndCall(3, 1, 30, 25);
`ifdef CALL_METER_DISCOUNT_EN
        loadLine(1, 30, 1'b1);
        applyStimulus(1, 3, 60, 1'b1);
`endif

        // random concurrent rounds
        repeat (12) begin
            for (int ln = 0; ln < CH; ln++)
                if ($urandom_range(0, 2) != 0) loadLine(ln, int'($urandom_range(0, 60)), 1'b1);
            for (int ln = 0; ln < CH; ln++) begin
                automatic int  l  = ln;
                automatic int  ty = int'($urandom_range(0, 3));
                automatic int  n  = int'($urandom_range(2, 200));
                automatic bit  d  = 1'($urandom_range(0, 1));
                fork
                    applyStimulus(l, ty, n, d);
                join_none
            end
            wait fork;
        end
        repeat (3) @(negedge clk);

        // reset in the middle of calls on every line
        for (int ln = 0; ln < CH; ln++) loadLine(ln, 40, 1'b1);
        @(negedge clk);
        call_type = 8'b11100100;
        calling = '1;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset");
        @(negedge clk);
        calling = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int ln = 0; ln < CH; ln++) bal[ln] = 0;
        repeat (3) @(negedge clk);
        loadLine(2, 12, 1'b1);
        applyStimulus(2, 1, 35, 1'b0);
        repeat (5) @(negedge clk);

        for (int ln = 0; ln < CH; ln++)
            check($sformatf("pending_records[%0d]", ln), longint'(expq[ln].size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
